// File: rtl/modinv_fermat_seq.sv
// Runtime-modulus modular inverse a^(q-2) mod q by constant-time square-and-multiply.
// Optional error status: define MODINV_ERR_EN to drive err; otherwise err is tied low.
module modinv_fermat_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] q,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         err
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SQR  = 3'd2;
    localparam logic [2:0] S_MUL  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [W-1:0]  ZERO    = {W{1'b0}};
    localparam logic [W-1:0]  ONE     = W'(1);
    localparam logic [W-1:0]  TWO     = W'(2);
    localparam logic [W-1:0]  THREE   = W'(3);
    localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [2:0]    state;
    logic [W-1:0]  a_in;
    logic [W-1:0]  q_r;
    logic [W-1:0]  a_r;
    logic [W-1:0]  e;
    logic [W-1:0]  p;
    logic [CW-1:0] cnt;
    logic          err_r;

    // Full 2W-bit product reduced mod m; a zero modulus yields zero instead of X.
    function automatic logic [W-1:0] mulmod(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic [W-1:0] m);
        logic [2*W-1:0] prod;
        logic [2*W-1:0] rem;
        prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        if (m == ZERO) begin
            rem = {(2*W){1'b0}};
        end else begin
            rem = prod % {{W{1'b0}}, m};
        end
        return rem[W-1:0];
    endfunction

    // Control FSM and datapath registers; every exponent bit costs one SQR and one MUL cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= ZERO;
            err_r  <= 1'b0;
            a_in   <= ZERO;
            q_r    <= ZERO;
            a_r    <= ZERO;
            e      <= ZERO;
            p      <= ONE;
            cnt    <= CNT_MAX;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_in  <= a;
                        q_r   <= q;
                        err_r <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    a_r <= (q_r == ZERO) ? ZERO : (a_in % q_r);
                    e   <= q_r - TWO;
                    cnt <= CNT_MAX;
                    if (q_r < THREE) begin
                        p     <= ZERO;
                        state <= S_DONE;
                    end else begin
                        p     <= ONE;
                        state <= S_SQR;
                    end
                end
                S_SQR: begin
                    p     <= mulmod(p, p, q_r);
                    state <= S_MUL;
                end
                S_MUL: begin
                    // The cycle is spent whether or not the bit is set, keeping timing data-independent.
                    if (e[cnt]) begin
                        p <= mulmod(p, a_r, q_r);
                    end else begin
                        p <= p;
                    end
                    if (cnt == {CW{1'b0}}) begin
                        state <= S_DONE;
                    end else begin
                        cnt   <= cnt - CNT_ONE;
                        state <= S_SQR;
                    end
                end
                S_DONE: begin
                    result <= p;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    err_r  <= (q_r < THREE) || (a_r == ZERO);
                    state  <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MODINV_ERR_EN
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_modinv_fermat_seq.sv
// Scoreboard bench for modinv_fermat_seq: expected results queued at start, checked at done.
module tb_modinv_fermat_seq;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_pass;
    logic [W-1:0] last_res;

    modinv_fermat_seq #(.W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .q      (q),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inverse by extended Euclid (independent of the exponentiation the DUT performs).
    function automatic logic [W-1:0] inv_model(input int unsigned ia, input int unsigned iq);
        longint t, nt, r, nr, qq, tmp;
        longint av;
        if (iq < 3) return '0;
        av = longint'(ia % iq);
        if (av == 0) return '0;
        t = 0; nt = 1; r = longint'(iq); nr = av;
        while (nr != 0) begin
            qq = r / nr;
            tmp = t - qq * nt; t = nt; nt = tmp;
            tmp = r - qq * nr; r = nr; nr = tmp;
        end
        if (t < 0) t = t + longint'(iq);
        return t[W-1:0];
    endfunction

    function automatic logic err_model(input int unsigned ia, input int unsigned iq);
`ifdef MODINV_ERR_EN
        if (iq < 3) return 1'b1;
        return (ia % iq) == 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] iq);
        exp_t ex;
        a = ia; q = iq; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ex.res = inv_model(ia, iq);
        ex.err = err_model(ia, iq);
        sb.push_back(ex);
    endtask

    // Waits for done (bounded), optionally firing a stray start at cycle inj, then scores the result.
    task automatic wait_done(input string tag, input int lat_lo, input int lat_hi, input int inj);
        int   lat;
        bit   seen;
        bit   busy_ok;
        exp_t ex;
        lat = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (lat == inj) begin
                    a = 16'd2; q = 16'd11; start = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
        end
        chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, "_done"}, {31'd0, seen}, 32'd1);
        if (lat_lo == lat_hi) chk({tag, "_lat"}, lat, lat_lo);
        else chk({tag, "_lat"}, {31'd0, (lat >= lat_lo && lat <= lat_hi)}, 32'd1);
        if (sb.size() > 0) begin
            ex = sb.pop_front();
            chk({tag, "_res"}, {16'd0, result}, {16'd0, ex.res});
            chk({tag, "_err"}, {31'd0, err}, {31'd0, ex.err});
        end
        last_res = result;
    endtask

    int unsigned primes[12] = '{3, 5, 7, 17, 97, 257, 7681, 12289, 40961, 65497, 65519, 65521};

    initial begin
        int   no_done;
        int unsigned rq, ra;
        n_chk = 0; n_pass = 0;
        reset = 1'b1; start = 1'b0; a = '0; q = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        issue(16'd3, 16'd7);      wait_done("q7a3", 34, 34, -1);
        issue(16'd10, 16'd7);     wait_done("q7a10", 34, 34, -1);
        issue(16'd2, 16'd65521);  wait_done("q65521a2", 34, 34, -1);
        chk("q65521a2_const", {16'd0, last_res}, 32'd32761);
        issue(16'd26, 16'd13);    wait_done("q13a26", 34, 34, -1);
        issue(16'd2, 16'd3);      wait_done("q3a2", 34, 34, -1);
        issue(16'd5, 16'd1);      wait_done("q1", 2, 3, -1);
        issue(16'd5, 16'd2);      wait_done("q2", 2, 3, -1);

        // Stray start mid-op with different operands must not disturb the result.
        issue(16'd3, 16'd7);      wait_done("ignored", 34, 34, 10);
        chk("ignored_const", {16'd0, last_res}, 32'd5);

        // Back-to-back: second start issued in the done cycle.
        issue(16'd4, 16'd11);     wait_done("b2b_1", 34, 34, -1);
        issue(16'd6, 16'd17);     wait_done("b2b_2", 34, 34, -1);

        // Reset mid-operation.
        issue(16'd3, 16'd7);
        void'(sb.pop_front());
        repeat (14) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_result", {16'd0, result}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        no_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) no_done++;
        end
        chk("midrst_quiet", no_done, 0);
        issue(16'd9, 16'd97);     wait_done("after_rst", 34, 34, -1);

        for (int i = 0; i < 20; i++) begin
            rq = primes[$urandom_range(0, 11)];
            ra = $urandom_range(0, 65535);
            if (ra % rq == 0) ra = ra + 1;
            issue(ra[W-1:0], rq[W-1:0]);
            wait_done("rand", 34, 34, -1);
            chk("rand_inv", (longint'(ra) * longint'(last_res)) % longint'(rq) == 1 ? 32'd1 : 32'd0, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
